// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer.
// Holds the direction-counter encodings, the small prediction struct
// used by both the fetch lookup and the resolve-time check, and the
// helpers that split a PC into table index and tag.
// PCs are passed through the helpers zero-extended to MAX_PC_W bits,
// so the buffer supports address widths up to MAX_PC_W.
package btb_pkg;

  localparam int MAX_CTR_W = 4;
  localparam int MAX_PC_W  = 64;

  // Outcome of looking a PC up in the table.
  typedef struct packed {
    logic hit;
    logic taken;
  } pred_t;

  // Weakly taken: MSB set, every other bit clear (1 when ctrW = 1).
  function automatic logic [MAX_CTR_W-1:0] weak_taken(input int ctrW);
    return MAX_CTR_W'(1) << (ctrW - 1);
  endfunction

  // Weakly not taken: MSB clear, every other bit set (0 when ctrW = 1).
  function automatic logic [MAX_CTR_W-1:0] weak_not_taken(input int ctrW);
    return (MAX_CTR_W'(1) << (ctrW - 1)) - MAX_CTR_W'(1);
  endfunction

  // Word-aligned index: pc[idxW+1:2].
  function automatic logic [MAX_PC_W-1:0] pc_index(input logic [MAX_PC_W-1:0] pc,
                                                   input int idxW);
    return (pc >> 2) & ((MAX_PC_W'(1) << idxW) - MAX_PC_W'(1));
  endfunction

  // Tag: everything above the index bits.
  function automatic logic [MAX_PC_W-1:0] pc_tag(input logic [MAX_PC_W-1:0] pc,
                                                 input int idxW);
    return pc >> (idxW + 2);
  endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// Saturating up/down counter next-value logic (purely combinational).
// Ports:
//   value_i     current counter value
//   inc_i       count up, stopping at all-ones
//   dec_i       count down, stopping at zero
//   force_max_i override: next value is all-ones
//   next_o      resulting counter value
module sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] value_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             force_max_i,
  output logic [CTR_W-1:0] next_o
);

  always_comb begin
    next_o = value_i;
    if (force_max_i) begin
      next_o = '1;
    end else if (inc_i && (value_i != '1)) begin
      next_o = value_i + CTR_W'(1);
    end else if (dec_i && (value_i != '0)) begin
      next_o = value_i - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry direction counters.
// Predicts the next fetch PC in IF with zero latency and is trained by
// branch/jump resolutions from ID.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   if_pc                           PC being fetched
//   pred_hit/pred_taken/pred_next_pc  fetch-side prediction
//   upd_valid/upd_pc/upd_taken/upd_target/upd_is_jump  resolution from ID
//   upd_mispredict                  prior prediction for upd_pc was wrong
//   invalidate                      clear every entry at the next edge
//   perf_updates/perf_mispredicts   saturating event counters
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_W    = 2,
  parameter int ALLOC_NT = 0,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_is_jump,
  output logic              upd_mispredict,
  input  logic              invalidate,
  output logic [PERF_W-1:0] perf_updates,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(weak_taken(CTR_W));
  localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(weak_not_taken(CTR_W));

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CTR_W-1:0]  ctr;
    logic              is_jump;
  } entry_t;

  entry_t            table_q [ENTRIES];
  entry_t            upd_entry_d;
  logic              write_en;
  logic [PERF_W-1:0] perf_updates_q, perf_updates_d;
  logic [PERF_W-1:0] perf_mispredicts_q, perf_mispredicts_d;

  logic [IDX_W-1:0]  if_idx, upd_idx;
  logic [TAG_W-1:0]  if_tag, upd_tag;
  pred_t             lookup, prior;
  logic [CTR_W-1:0]  ctr_next;

  assign if_idx  = IDX_W'(pc_index(MAX_PC_W'(if_pc), IDX_W));
  assign if_tag  = TAG_W'(pc_tag(MAX_PC_W'(if_pc), IDX_W));
  assign upd_idx = IDX_W'(pc_index(MAX_PC_W'(upd_pc), IDX_W));
  assign upd_tag = TAG_W'(pc_tag(MAX_PC_W'(upd_pc), IDX_W));

  // Fetch-side lookup reads the registered table, so a same-cycle write
  // to the same index only becomes visible on the following cycle.
  always_comb begin
    lookup.hit   = table_q[if_idx].valid && (table_q[if_idx].tag == if_tag);
    lookup.taken = lookup.hit &&
                   (table_q[if_idx].is_jump || table_q[if_idx].ctr[CTR_W-1]);
  end

  assign pred_hit     = lookup.hit;
  assign pred_taken   = lookup.taken;
  assign pred_next_pc = lookup.taken ? table_q[if_idx].target : if_pc + ADDR_W'(4);

  // Direction the table would have predicted for the resolving PC.
  always_comb begin
    prior.hit   = table_q[upd_idx].valid && (table_q[upd_idx].tag == upd_tag);
    prior.taken = prior.hit &&
                  (table_q[upd_idx].is_jump || table_q[upd_idx].ctr[CTR_W-1]);
  end

  // A taken prediction to the wrong target counts as a mispredict too.
  assign upd_mispredict = upd_valid &&
                          ((prior.taken != upd_taken) ||
                           (upd_taken && prior.taken &&
                            (table_q[upd_idx].target != upd_target)));

  sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
    .value_i     (table_q[upd_idx].ctr),
    .inc_i       (upd_taken),
    .dec_i       (!upd_taken),
    .force_max_i (table_q[upd_idx].is_jump),
    .next_o      (ctr_next)
  );

  always_comb begin
    upd_entry_d = table_q[upd_idx];
    write_en    = 1'b0;
    if (upd_valid && !invalidate) begin
      if (prior.hit) begin
        write_en        = 1'b1;
        upd_entry_d.ctr = ctr_next;
        if (upd_taken) begin
          upd_entry_d.target = upd_target;
        end
      end else if (upd_taken || (ALLOC_NT != 0)) begin
        write_en            = 1'b1;
        upd_entry_d.valid   = 1'b1;
        upd_entry_d.tag     = upd_tag;
        upd_entry_d.target  = upd_target;
        upd_entry_d.ctr     = upd_taken ? WEAK_T : WEAK_NT;
        upd_entry_d.is_jump = upd_is_jump;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid   <= 1'b0;
        table_q[i].tag     <= '0;
        table_q[i].target  <= '0;
        table_q[i].ctr     <= WEAK_NT;
        table_q[i].is_jump <= 1'b0;
      end
    end else if (invalidate) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
      end
    end else if (write_en) begin
      table_q[upd_idx] <= upd_entry_d;
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_comb begin
    perf_updates_d     = perf_updates_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (upd_valid && (perf_updates_q != '1)) begin
      perf_updates_d = perf_updates_q + PERF_W'(1);
    end
    if (upd_mispredict && (perf_mispredicts_q != '1)) begin
      perf_mispredicts_d = perf_mispredicts_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_updates_q     <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      perf_updates_q     <= perf_updates_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_updates     = perf_updates_q;
  assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer (ENTRIES=16, CTR_W=2, PERF_W=4).
// Expected values are queued as each step is driven and drained against
// the outputs one time unit after the falling edge.
module tb_branch_target_buffer;

  localparam int PERF_W = 4;
  localparam logic [31:0] PERF_MAX = 32'd15;

  localparam int SEL_HIT  = 0;
  localparam int SEL_TAKE = 1;
  localparam int SEL_NPC  = 2;
  localparam int SEL_MISP = 3;
  localparam int SEL_PUPD = 4;
  localparam int SEL_PMIS = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       if_pc;
  logic              pred_hit, pred_taken;
  logic [31:0]       pred_next_pc;
  logic              upd_valid, upd_taken, upd_is_jump, invalidate;
  logic [31:0]       upd_pc, upd_target;
  logic              upd_mispredict;
  logic [PERF_W-1:0] perf_updates, perf_mispredicts;

  exp_t        sb[$];
  int          numChecks = 0;
  int          numErrors = 0;
  logic [31:0] expUpd = 0;
  logic [31:0] expMis = 0;
  logic        pendUpd = 1'b0;
  logic        pendMis = 1'b0;

  branch_target_buffer #(
    .ADDR_W(32), .ENTRIES(16), .CTR_W(2), .ALLOC_NT(0), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_is_jump(upd_is_jump),
    .upd_mispredict(upd_mispredict), .invalidate(invalidate),
    .perf_updates(perf_updates), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] observed(input int sel);
    case (sel)
      SEL_HIT:  return {31'b0, pred_hit};
      SEL_TAKE: return {31'b0, pred_taken};
      SEL_NPC:  return pred_next_pc;
      SEL_MISP: return {31'b0, upd_mispredict};
      SEL_PUPD: return {28'b0, perf_updates};
      default:  return {28'b0, perf_mispredicts};
    endcase
  endfunction

  task automatic expectVal(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [31:0] pcIf, input logic uv,
                               input logic [31:0] upc, input logic ut,
                               input logic [31:0] utgt, input logic uj,
                               input logic inv);
    @(negedge clk);
    if_pc = pcIf; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_is_jump = uj; invalidate = inv;
  endtask

  // Drive one cycle and queue the mispredict flag plus the perf counters
  // expected from all earlier cycles.
  task automatic step(input logic [31:0] pcIf, input logic uv,
                      input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic uj,
                      input logic inv, input logic expMisp);
    applyStimulus(pcIf, uv, upc, ut, utgt, uj, inv);
    expectVal("upd_mispredict", SEL_MISP, {31'b0, expMisp});
    expectVal("perf_updates", SEL_PUPD, expUpd);
    expectVal("perf_mispredicts", SEL_PMIS, expMis);
    pendUpd = uv;
    pendMis = expMisp;
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observed(e.sel);
      numChecks++;
      assert (obs === e.exp) else begin
        numErrors++;
        $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
    if (pendUpd && expUpd != PERF_MAX) expUpd++;
    if (pendMis && expMis != PERF_MAX) expMis++;
    pendUpd = 1'b0;
    pendMis = 1'b0;
  endtask

  task automatic expectLookup(input logic hit, input logic taken, input logic [31:0] npc);
    expectVal("pred_hit", SEL_HIT, {31'b0, hit});
    expectVal("pred_taken", SEL_TAKE, {31'b0, taken});
    expectVal("pred_next_pc", SEL_NPC, npc);
  endtask

  initial begin
    reset = 1'b1; if_pc = 32'h0040_0010; upd_valid = 0; upd_pc = 0;
    upd_taken = 0; upd_target = 0; upd_is_jump = 0; invalidate = 0;
    @(negedge clk);
    expectLookup(1'b0, 1'b0, 32'h0040_0014);
    expectVal("reset perf_updates", SEL_PUPD, 0);
    expectVal("reset perf_mispredicts", SEL_PMIS, 0);
    checkOutput();
    reset = 1'b0;

    step(32'h0040_0010, 0, 0, 0, 0, 0, 0, 0);
    expectLookup(1'b0, 1'b0, 32'h0040_0014);
    checkOutput();

    // First taken resolution misses; lookup still sees the old table.
    step(32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0040, 0, 0, 1);
    expectLookup(1'b0, 1'b0, 32'h0040_0014);
    checkOutput();

    step(32'h0040_0010, 0, 0, 0, 0, 0, 0, 0);
    expectLookup(1'b1, 1'b1, 32'h0040_0040);
    checkOutput();

    // Two not-taken resolutions: 10 -> 01 (mispredict), 01 -> 00.
    step(32'h0040_0010, 1, 32'h0040_0010, 0, 0, 0, 0, 1);
    checkOutput();
    step(32'h0040_0010, 1, 32'h0040_0010, 0, 0, 0, 0, 0);
    expectLookup(1'b1, 1'b0, 32'h0040_0014);
    checkOutput();
    step(32'h0040_0010, 0, 0, 0, 0, 0, 0, 0);
    expectLookup(1'b1, 1'b0, 32'h0040_0014);
    checkOutput();

    // Aliasing jump at 0x0040_0050 evicts 0x0040_0010 from index 4.
    step(32'h0040_0010, 1, 32'h0040_0050, 1, 32'h0040_0100, 1, 0, 1);
    expectLookup(1'b1, 1'b0, 32'h0040_0014);
    checkOutput();
    step(32'h0040_0010, 0, 0, 0, 0, 0, 0, 0);
    expectLookup(1'b0, 1'b0, 32'h0040_0014);
    checkOutput();

    // Taken to a new target on a hit is a target mispredict.
    step(32'h0040_0050, 1, 32'h0040_0050, 1, 32'h0040_0200, 1, 0, 1);
    expectLookup(1'b1, 1'b1, 32'h0040_0100);
    checkOutput();
    step(32'h0040_0050, 1, 32'h0040_0050, 1, 32'h0040_0200, 1, 0, 0);
    expectLookup(1'b1, 1'b1, 32'h0040_0200);
    checkOutput();

    // Invalidate wins over a same-cycle allocation.
    step(32'h0040_0050, 1, 32'h0040_0090, 1, 32'h0040_0300, 0, 1, 1);
    expectLookup(1'b1, 1'b1, 32'h0040_0200);
    checkOutput();
    step(32'h0040_0050, 0, 0, 0, 0, 0, 0, 0);
    expectLookup(1'b0, 1'b0, 32'h0040_0054);
    checkOutput();
    step(32'h0040_0090, 0, 0, 0, 0, 0, 0, 0);
    expectLookup(1'b0, 1'b0, 32'h0040_0094);
    checkOutput();

    // +4 wraps at the top of the address space.
    step(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
    expectLookup(1'b0, 1'b0, 32'h0000_0000);
    checkOutput();

    // Not-taken miss does not allocate.
    step(32'h0040_0020, 1, 32'h0040_0020, 0, 32'h0040_0800, 0, 0, 0);
    checkOutput();
    step(32'h0040_0020, 0, 0, 0, 0, 0, 0, 0);
    expectLookup(1'b0, 1'b0, 32'h0040_0024);
    checkOutput();

    // Twenty mispredicting updates drive both counters into saturation.
    for (int i = 0; i < 20; i++) begin
      step(32'h0040_0010, 1, 32'h0040_0010 + 32'(i * 4), 1, 32'h0040_1000, 0, 1, 1);
      checkOutput();
    end
    step(32'h0040_0010, 0, 0, 0, 0, 0, 0, 0);
    expectVal("saturated perf_updates", SEL_PUPD, 32'd15);
    expectVal("saturated perf_mispredicts", SEL_PMIS, 32'd15);
    checkOutput();

    // Reset during an update: the update is lost and counters clear.
    applyStimulus(32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0040, 0, 0);
    reset = 1'b1;
    expUpd = 0; expMis = 0;
    expectVal("reset upd_mispredict", SEL_MISP, 1);
    expectVal("reset perf_updates", SEL_PUPD, 0);
    expectVal("reset perf_mispredicts", SEL_PMIS, 0);
    checkOutput();
    applyStimulus(32'h0040_0010, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    expectLookup(1'b0, 1'b0, 32'h0040_0014);
    expectVal("post-reset perf_updates", SEL_PUPD, 0);
    expectVal("post-reset perf_mispredicts", SEL_PMIS, 0);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
